// File: rtl/versatile_fifo_sync_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// versatile_fifo_sync_ctrl_pkg
// Shared definitions for the versatile FIFO family. The quadrant and direction
// encodings are common with the asynchronous comparator variant. The
// single-clock controller uses only the pointer-width extension.
// -----------------------------------------------------------------------------
package versatile_fifo_sync_ctrl_pkg;

    // Pointer quadrant encodings (top two Gray-coded pointer bits in the async
    // variant).
    typedef enum logic [1:0] {
        Q1 = 2'b00,
        Q2 = 2'b01,
        Q3 = 2'b11,
        Q4 = 2'b10
    } quadrant_e;

    // Direction latch states of the async comparator.
    typedef enum logic {
        GOING_EMPTY = 1'b0,
        GOING_FULL  = 1'b1
    } direction_e;

    // Number of extra pointer bits beyond the RAM address. The single wrap bit
    // makes full and empty unambiguous without a direction latch.
    localparam int PTR_EXTRA = 1;

endpackage

// File: rtl/versatile_fifo_sync_ptr.sv
// -----------------------------------------------------------------------------
// versatile_fifo_sync_ptr
// Binary pointer counter with increment enable and synchronous clear. It rolls
// over naturally from all-ones to zero.
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   clr_i  in   synchronous clear (same effect as rst)
//   inc_i  in   increment enable
//   ptr_o  out  PTR_W-bit pointer value
// -----------------------------------------------------------------------------
module versatile_fifo_sync_ptr #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/versatile_fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// versatile_fifo_sync_ctrl
// Single-clock FIFO controller. It drives an external simple dual-port RAM of
// 2**ADDR_WIDTH words and generates the following:
//   - RAM read/write addresses and gated enables
//   - registered full/empty/almost-full/almost-empty flags
//   - a registered fill level
//   - sticky overflow/underflow flags
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clr                   synchronous flush (thresholds kept)
//   wr_en, rd_en          write / read requests
//   lvl_we                load afull_lvl / aempty_lvl thresholds
//   afull_lvl, aempty_lvl thresholds (ADDR_WIDTH+1 bits)
//   wptr, rptr            RAM write / read address
//   wr_ok, rd_ok          RAM write / read enable (accepted request)
//   fifo_full, fifo_empty, fifo_afull, fifo_aempty   registered flags
//   fill                  occupancy 0..DEPTH
//   overflow, underflow   sticky error flags
// -----------------------------------------------------------------------------
module versatile_fifo_sync_ctrl
    import versatile_fifo_sync_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_RST  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_RST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  lvl_we,
    input  logic [ADDR_WIDTH:0]   afull_lvl,
    input  logic [ADDR_WIDTH:0]   aempty_lvl,
    output logic [ADDR_WIDTH-1:0] wptr,
    output logic [ADDR_WIDTH-1:0] rptr,
    output logic                  wr_ok,
    output logic                  rd_ok,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_afull,
    output logic                  fifo_aempty,
    output logic [ADDR_WIDTH:0]   fill,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + PTR_EXTRA;

    logic [PTR_W-1:0] wptr_full, rptr_full;
    logic [PTR_W-1:0] wptr_nxt,  rptr_nxt;

    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             afull_q,  afull_d;
    logic             aempty_q, aempty_d;
    logic [PTR_W-1:0] fill_q,   fill_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic [PTR_W-1:0] afull_lvl_q;
    logic [PTR_W-1:0] aempty_lvl_q;

    // Requests are qualified only by the registered flags. A flush or reset
    // in the same cycle suppresses both so the RAM is never written/read.
    assign wr_ok = wr_en & ~full_q  & ~clr & ~rst;
    assign rd_ok = rd_en & ~empty_q & ~clr & ~rst;

    versatile_fifo_sync_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (wr_ok),
        .ptr_o (wptr_full)
    );

    versatile_fifo_sync_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (rd_ok),
        .ptr_o (rptr_full)
    );

    // Flags are computed from the pointer/fill values the registers will hold
    // after this edge, so they are aligned with the pointers they describe.
    always_comb begin
        wptr_nxt = wptr_full + PTR_W'(wr_ok);
        rptr_nxt = rptr_full + PTR_W'(rd_ok);
        fill_d   = fill_q + PTR_W'(wr_ok) - PTR_W'(rd_ok);
        ovf_d    = ovf_q | (wr_en & full_q);
        unf_d    = unf_q | (rd_en & empty_q);
        if (clr) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
            fill_d   = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
        // Full: same RAM address, opposite wrap bit. Empty: identical pointers.
        full_d   = (wptr_nxt[PTR_W-1] != rptr_nxt[PTR_W-1]) &&
                   (wptr_nxt[PTR_W-2:0] == rptr_nxt[PTR_W-2:0]);
        empty_d  = (wptr_nxt == rptr_nxt);
        afull_d  = (fill_d >= afull_lvl_q);
        aempty_d = (fill_d <= aempty_lvl_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            afull_q      <= (AFULL_RST == 0);
            aempty_q     <= 1'b1;
            fill_q       <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            afull_lvl_q  <= AFULL_RST[PTR_W-1:0];
            aempty_lvl_q <= AEMPTY_RST[PTR_W-1:0];
        end else begin
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            // Thresholds survive a flush; out-of-range values are taken as-is.
            if (lvl_we) begin
                afull_lvl_q  <= afull_lvl;
                aempty_lvl_q <= aempty_lvl;
            end
        end
    end

    assign wptr        = wptr_full[ADDR_WIDTH-1:0];
    assign rptr        = rptr_full[ADDR_WIDTH-1:0];
    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign fifo_afull  = afull_q;
    assign fifo_aempty = aempty_q;
    assign fill        = fill_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule
